pila_retorno: RTL and testbench
===============================

// Module: pila_retorno
// PURPOSE
//  Return-address stack (LIFO) sitting directly downstream of the program counter.
//  - On a call it captures the PC's call address and stores (address + 1).
//  - On a return it presents the saved address as the jump target fed back to the PC.
//  - Gives the microprocessor nested subroutine calls without using data memory.
// PARAMETERS
//  ADDR_W   8   width of instruction addresses stored/returned
//  DEPTH    8   number of stack entries (power of two not required, >=2)
// PORTS
//  i_Clk                  in   1         single system clock, all state on rising edge
//  i_Rst                  in   1         synchronous reset, active-high
//  i_Push                 in   1         call strobe (PC control_saltos == 2'b10)
//  i_Pop                  in   1         return strobe
//  i_Direccion_PC         in   ADDR_W    address of the call instruction (PC call output)
//  o_Direccion_Retorno    out  ADDR_W    top-of-stack return address, 0 when empty
//  o_Vacio                out  1         stack empty
//  o_Lleno                out  1         stack holds DEPTH entries
//  o_Nivel                out  $clog2(DEPTH+1)  current entry count
//  o_Error_Overflow       out  1         sticky overflow (STACK_ERR_FLAGS_EN only)
//  o_Error_Underflow      out  1         sticky underflow (STACK_ERR_FLAGS_EN only)
// BEHAVIOUR
//  - Reset (sync, i_Rst=1 at posedge): nivel=0, o_Vacio=1, o_Lleno=0, o_Direccion_Retorno=0, error flags=0.
//    Reset wins over any push/pop in the same cycle.
//    Entry storage is not cleared.
//  - Push value: i_Direccion_PC + 1, mod 2^ADDR_W (255 -> 0 for ADDR_W=8).
//  - Push only, not full: write to entry[nivel], nivel+1; new top visible the next cycle.
//  - Pop only, not empty: nivel-1. o_Direccion_Retorno is combinational from the registered top,
//    so the PC samples it in the same cycle the pop is asserted (zero-latency read, one-cycle update).
//  - Push+pop same cycle, not empty: top entry overwritten with the new value; nivel unchanged.
//  - Push+pop same cycle, empty: pop ignored (counts as underflow); push proceeds; nivel=1.
//  - Push when full (without pop): ignored, contents and nivel unchanged; overflow event.
//  - Pop when empty: ignored, o_Direccion_Retorno stays 0; underflow event.
//  - o_Vacio = (nivel==0); o_Lleno = (nivel==DEPTH); both derived from the registered nivel.
//  - No state machine beyond the level counter. Nivel saturates in [0, DEPTH] and never wraps.
// CONFIGURATION
//  - Macro STACK_ERR_FLAGS_EN defined:
//    o_Error_Overflow and o_Error_Underflow are sticky; set the cycle after the event;
//    cleared only by i_Rst.
//  - Macro undefined: both ports exist but are tied to 0. Overflow/underflow are silently dropped.
// STRUCTURE
//  - Shared package/include pila_defs:
//    - ADDR_W and DEPTH defaults.
//    - Salto encodings: SALTO_SEC=2'b00, SALTO_JMP=2'b01, SALTO_CALL=2'b10.
//  - Single module, no sub-module. Storage is a reg array [0:DEPTH-1] plus a level counter.
// TESTING
//  1. Reset then idle: o_Vacio=1, o_Nivel=0, o_Direccion_Retorno=0.
//  2. Push with PC=8'h10, then PC=8'h20:
//     o_Nivel=2, top=8'h21; pop -> top=8'h11, nivel=1.
//  3. Push with PC=8'hFF: stored 8'h00 (wrap); pop returns 8'h00, o_Vacio=1.
//  4. Push 8 times (PC=0..7): o_Lleno=1. 9th push PC=8'h50 ignored: top=8'h08,
//     o_Error_Overflow=1 (with macro).
//  5. Pop on empty: nivel stays 0, output 0, o_Error_Underflow=1.
//     Push+pop with nivel=3, top=8'h31, PC=8'h40: top=8'h41, nivel=3.
//  6. Reset asserted mid-sequence with nivel=4 and push high: next cycle nivel=0, flags cleared.

Source files
------------

// File: rtl/pila_defs.sv
// Shared definitions for the return-address stack: default sizes, the
// program-counter jump encodings and the per-cycle stack operation type.
package pila_defs;

    // Default width of an instruction address and number of stack entries
    localparam int ADDR_W_DEF = 8;
    localparam int DEPTH_DEF  = 8;

    // Program-counter jump control encodings (control_saltos)
    typedef enum logic [1:0] {
        SALTO_SEC  = 2'b00,
        SALTO_JMP  = 2'b01,
        SALTO_CALL = 2'b10
    } salto_t;

    // Stack operation requested in a cycle, encoded as {push, pop}
    typedef enum logic [1:0] {
        OP_NADA = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_SWAP = 2'b11
    } pila_op_t;

    // Return address saved for a call at address pc (wraps modulo 2^width)
    function automatic logic [ADDR_W_DEF-1:0] ret_addr_def(input logic [ADDR_W_DEF-1:0] pc);
        return pc + ADDR_W_DEF'(1);
    endfunction

endpackage

// File: rtl/pila_retorno.sv
// Return-address stack (LIFO) placed after the program counter.
// A call pushes (call address + 1); a return pops, and the top of stack is
// presented combinationally so the PC can jump in the same cycle.
// Optional macro STACK_ERR_FLAGS_EN enables sticky overflow/underflow flags;
// without it both flag ports are tied to 0 and the events are dropped.
module pila_retorno
    import pila_defs::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                       i_Clk,
    input  logic                       i_Rst,
    input  logic                       i_Push,
    input  logic                       i_Pop,
    input  logic [ADDR_W-1:0]          i_Direccion_PC,
    output logic [ADDR_W-1:0]          o_Direccion_Retorno,
    output logic                       o_Vacio,
    output logic                       o_Lleno,
    output logic [$clog2(DEPTH+1)-1:0] o_Nivel,
    output logic                       o_Error_Overflow,
    output logic                       o_Error_Underflow
);

    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LVL_W-1:0] NIVEL_MAX = LVL_W'(DEPTH);

    // Entry storage; not cleared by reset, only entries below nivel are meaningful
    logic [ADDR_W-1:0] mem_reg [0:DEPTH-1];

    logic [LVL_W-1:0]  nivel_reg;
    logic [LVL_W-1:0]  nivel_next;
    logic              vacio;
    logic              lleno;
    pila_op_t          op;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  top_idx;
    logic [ADDR_W-1:0] push_val;

    assign vacio    = (nivel_reg == '0);
    assign lleno    = (nivel_reg == NIVEL_MAX);
    assign op       = pila_op_t'({i_Push, i_Pop});
    assign push_val = i_Direccion_PC + ADDR_W'(1);
    assign top_idx  = IDX_W'(nivel_reg - LVL_W'(1));

    // Decide the next level and where (if anywhere) the new return address goes
    always_comb begin
        nivel_next = nivel_reg;
        wr_en      = 1'b0;
        wr_idx     = IDX_W'(nivel_reg);
        unique case (op)
            OP_PUSH: begin
                // A full stack ignores the call entirely
                if (!lleno) begin
                    wr_en      = 1'b1;
                    wr_idx     = IDX_W'(nivel_reg);
                    nivel_next = nivel_reg + LVL_W'(1);
                end
            end
            OP_POP: begin
                // An empty stack ignores the return; output stays at 0
                if (!vacio) begin
                    nivel_next = nivel_reg - LVL_W'(1);
                end
            end
            OP_SWAP: begin
                if (vacio) begin
                    // Nothing to return from: the pop is dropped, the call proceeds
                    wr_en      = 1'b1;
                    wr_idx     = '0;
                    nivel_next = LVL_W'(1);
                end else begin
                    // Return and call together replace the top entry in place
                    wr_en  = 1'b1;
                    wr_idx = top_idx;
                end
            end
            default: begin
                nivel_next = nivel_reg;
            end
        endcase
    end

    // Level counter, saturating in [0, DEPTH]; reset wins over any operation
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            nivel_reg <= '0;
        end else begin
            nivel_reg <= nivel_next;
        end
    end

    // Entry write; gated by reset so a call in the reset cycle leaves storage untouched
    always_ff @(posedge i_Clk) begin
        if (!i_Rst && wr_en) begin
            mem_reg[wr_idx] <= push_val;
        end
    end

    // Top of stack is read combinationally so a return can jump without waiting
    assign o_Direccion_Retorno = vacio ? '0 : mem_reg[top_idx];
    assign o_Vacio             = vacio;
    assign o_Lleno             = lleno;
    assign o_Nivel             = nivel_reg;

`ifdef STACK_ERR_FLAGS_EN
    logic ev_overflow;
    logic ev_underflow;
    logic overflow_reg;
    logic underflow_reg;

    // A call on a full stack without a matching return is lost
    assign ev_overflow  = (op == OP_PUSH) && lleno;
    // Any return on an empty stack is lost, even when paired with a call
    assign ev_underflow = i_Pop && vacio;

    // Sticky error flags, visible the cycle after the event, cleared only by reset
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (ev_overflow) begin
                overflow_reg <= 1'b1;
            end
            if (ev_underflow) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    assign o_Error_Overflow  = overflow_reg;
    assign o_Error_Underflow = underflow_reg;
`else
    assign o_Error_Overflow  = 1'b0;
    assign o_Error_Underflow = 1'b0;
`endif

endmodule

// File: tb/tb_pila_retorno.sv
// Self-checking bench for pila_retorno: directed scenarios with literal
// expectations followed by randomized push/pop/reset traffic, all checked
// every cycle against a queue-based model of the return stack.
module tb_pila_retorno;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 8;
    localparam int LVL_W  = $clog2(DEPTH + 1);

`ifdef STACK_ERR_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] ret;
    logic              vacio;
    logic              lleno;
    logic [LVL_W-1:0]  nivel;
    logic              err_ov;
    logic              err_un;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    pila_retorno #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .i_Clk               (clk),
        .i_Rst               (rst),
        .i_Push              (push),
        .i_Pop               (pop),
        .i_Direccion_PC      (pc),
        .o_Direccion_Retorno (ret),
        .o_Vacio             (vacio),
        .o_Lleno             (lleno),
        .o_Nivel             (nivel),
        .o_Error_Overflow    (err_ov),
        .o_Error_Underflow   (err_un)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue whose back is the top of stack
    logic [ADDR_W-1:0] q[$];
    bit m_over  = 1'b0;
    bit m_under = 1'b0;
    bit model_ok = 1'b0;

    initial begin
        forever begin
            logic [ADDR_W-1:0] v;
            @(posedge clk);
            v = pc + 8'd1;
            if (rst) begin
                q.delete();
                m_over   = 1'b0;
                m_under  = 1'b0;
                model_ok = 1'b1;
            end else if (model_ok) begin
                if (push && pop) begin
                    if (q.size() == 0) begin
                        if (FLAGS) m_under = 1'b1;
                        q.push_back(v);
                    end else begin
                        q[q.size()-1] = v;
                    end
                end else if (push) begin
                    if (q.size() == DEPTH) begin
                        if (FLAGS) m_over = 1'b1;
                    end else begin
                        q.push_back(v);
                    end
                end else if (pop) begin
                    if (q.size() == 0) begin
                        if (FLAGS) m_under = 1'b1;
                    end else begin
                        void'(q.pop_back());
                    end
                end
            end
        end
    end

    // Compare every cycle, on the falling edge, once the model has seen a reset
    initial begin
        forever begin
            @(negedge clk);
            if (model_ok) begin
                check("m_nivel", 32'(nivel), 32'(q.size()));
                check("m_ret", 32'(ret), (q.size() == 0) ? 32'd0 : 32'(q[q.size()-1]));
                check("m_vacio", 32'(vacio), 32'(q.size() == 0));
                check("m_lleno", 32'(lleno), 32'(q.size() == DEPTH));
                check("m_ovf", 32'(err_ov), 32'(m_over));
                check("m_unf", 32'(err_un), 32'(m_under));
            end
        end
    end

    task automatic drive(input logic r, input logic pu, input logic po, input logic [ADDR_W-1:0] a);
        rst  = r;
        push = pu;
        pop  = po;
        pc   = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic r, input logic pu, input logic po, input logic [ADDR_W-1:0] a);
        drive(r, pu, po, a);
        tick();
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        op(1'b1, 1'b0, 1'b0, 8'h00);

        // 1. reset then idle
        op(1'b0, 1'b0, 1'b0, 8'h00);
        $display("txn reset+idle: nivel=%0d vacio=%0b ret=%02h", nivel, vacio, ret);
        check("reset_vacio", 32'(vacio), 32'd1);
        check("reset_nivel", 32'(nivel), 32'd0);
        check("reset_ret", 32'(ret), 32'h00);

        // 2. two calls then one return
        op(1'b0, 1'b1, 1'b0, 8'h10);
        op(1'b0, 1'b1, 1'b0, 8'h20);
        $display("txn push 10,20: nivel=%0d top=%02h", nivel, ret);
        check("two_push_nivel", 32'(nivel), 32'd2);
        check("two_push_top", 32'(ret), 32'h21);
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        #1;
        check("pop_same_cycle_ret", 32'(ret), 32'h21);
        tick();
        $display("txn pop: nivel=%0d top=%02h", nivel, ret);
        check("pop_top", 32'(ret), 32'h11);
        check("pop_nivel", 32'(nivel), 32'd1);
        op(1'b0, 1'b0, 1'b1, 8'h00);

        // 3. address wrap
        op(1'b0, 1'b1, 1'b0, 8'hFF);
        $display("txn push FF: nivel=%0d top=%02h", nivel, ret);
        check("wrap_top", 32'(ret), 32'h00);
        check("wrap_nivel", 32'(nivel), 32'd1);
        op(1'b0, 1'b0, 1'b1, 8'h00);
        check("wrap_pop_vacio", 32'(vacio), 32'd1);

        // 4. fill, then overflow
        for (int i = 0; i < DEPTH; i++) op(1'b0, 1'b1, 1'b0, 8'(i));
        check("full_lleno", 32'(lleno), 32'd1);
        check("full_top", 32'(ret), 32'h08);
        op(1'b0, 1'b1, 1'b0, 8'h50);
        $display("txn push 50 on full: nivel=%0d top=%02h ovf=%0b", nivel, ret, err_ov);
        check("ovf_top", 32'(ret), 32'h08);
        check("ovf_nivel", 32'(nivel), 32'd8);
        check("ovf_flag", 32'(err_ov), 32'(FLAGS));

        // 5. underflow, then push+pop swap
        op(1'b1, 1'b0, 1'b0, 8'h00);
        op(1'b0, 1'b0, 1'b1, 8'h00);
        $display("txn pop on empty: nivel=%0d ret=%02h unf=%0b", nivel, ret, err_un);
        check("unf_nivel", 32'(nivel), 32'd0);
        check("unf_ret", 32'(ret), 32'h00);
        check("unf_flag", 32'(err_un), 32'(FLAGS));
        check("unf_no_ovf", 32'(err_ov), 32'd0);
        op(1'b0, 1'b1, 1'b0, 8'h10);
        op(1'b0, 1'b1, 1'b0, 8'h20);
        op(1'b0, 1'b1, 1'b0, 8'h30);
        check("pre_swap_top", 32'(ret), 32'h31);
        op(1'b0, 1'b1, 1'b1, 8'h40);
        $display("txn push+pop 40: nivel=%0d top=%02h", nivel, ret);
        check("swap_top", 32'(ret), 32'h41);
        check("swap_nivel", 32'(nivel), 32'd3);

        // 6. reset mid-sequence with a push pending
        op(1'b0, 1'b1, 1'b0, 8'h60);
        check("pre_rst_nivel", 32'(nivel), 32'd4);
        op(1'b1, 1'b1, 1'b0, 8'h70);
        $display("txn reset with push: nivel=%0d vacio=%0b unf=%0b", nivel, vacio, err_un);
        check("rst_nivel", 32'(nivel), 32'd0);
        check("rst_vacio", 32'(vacio), 32'd1);
        check("rst_unf", 32'(err_un), 32'd0);
        check("rst_ovf", 32'(err_ov), 32'd0);

        // Push+pop on an empty stack
        op(1'b0, 1'b1, 1'b1, 8'h90);
        check("swap_empty_nivel", 32'(nivel), 32'd1);
        check("swap_empty_top", 32'(ret), 32'h91);
        check("swap_empty_unf", 32'(err_un), 32'(FLAGS));

        // Randomized traffic, checked by the model every cycle
        for (int n = 0; n < 3000; n++) begin
            logic r;
            logic pu;
            logic po;
            logic [ADDR_W-1:0] a;
            r  = ($urandom_range(0, 149) == 0);
            pu = ($urandom_range(0, 99) < 55);
            po = ($urandom_range(0, 99) < 45);
            a  = 8'($urandom);
            op(r, pu, po, a);
            if (n % 500 == 0)
                $display("txn rand %0d: push=%0b pop=%0b pc=%02h nivel=%0d top=%02h", n, pu, po, a, nivel, ret);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
